// File: rtl/button_event_unit.sv
// button_event_unit: conditions the board push-buttons.
// Each raw pad is synchronised with two flops and debounced. The debounced
// level then drives a per-button event FSM that emits one-cycle pulses on a
// press and, for masked buttons, auto-repeat pulses while the button is held.
// level and pulse are plain per-cycle registered outputs with no handshake.
// state_dbg exposes each channel's FSM state as {state[N_BTN-1], ..., state[0]},
// two bits per channel (0=IDLE, 1=HOLD, 2=REPEAT).
module button_event_unit #(
  parameter int               N_BTN           = 5,
  parameter int               DEBOUNCE_CYCLES = 1_000_000,
  parameter int               REPEAT_DELAY    = 50_000_000,
  parameter int               REPEAT_RATE     = 10_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b11000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   level,
  output logic [N_BTN-1:0]   pulse,
  output logic [2*N_BTN-1:0] state_dbg
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } ev_state_e;

  logic [N_BTN-1:0] s1_q;
  logic [N_BTN-1:0] s2_q;

  // Two-flop synchroniser bringing the asynchronous pads into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [DW-1:0] dcnt_q;
    logic          level_q;
    logic [RW-1:0] rcnt_q;
    logic          pulse_q;
    ev_state_e     state_q;

    // Debounce: level follows s2 only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; a single agreeing sample restarts the count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dcnt_q  <= '0;
        level_q <= 1'b0;
      end else if (s2_q[g] == level_q) begin
        dcnt_q <= '0;
      end else if (dcnt_q == D_LAST) begin
        level_q <= s2_q[g];
        dcnt_q  <= '0;
      end else begin
        dcnt_q <= dcnt_q + 1'b1;
      end
    end

    // Event FSM: press pulse on entry to HOLD, then optional delayed and
    // periodic repeat pulses; pulse defaults low every cycle.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        rcnt_q  <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (level_q) begin
              pulse_q <= 1'b1;
              rcnt_q  <= '0;
              state_q <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (!level_q) begin
              rcnt_q  <= '0;
              state_q <= ST_IDLE;
            end else if (REPEAT_MASK[g]) begin
              if (rcnt_q == RD_LAST) begin
                pulse_q <= 1'b1;
                rcnt_q  <= '0;
                state_q <= ST_REPEAT;
              end else begin
                rcnt_q <= rcnt_q + 1'b1;
              end
            end
          end
          ST_REPEAT: begin
            if (!level_q) begin
              rcnt_q  <= '0;
              state_q <= ST_IDLE;
            end else if (rcnt_q == RR_LAST) begin
              pulse_q <= 1'b1;
              rcnt_q  <= '0;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          default: begin
            rcnt_q  <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end

    assign level[g]           = level_q;
    assign pulse[g]           = pulse_q;
    assign state_dbg[2*g +: 2] = state_q;
  end

endmodule

// File: tb/tb_button_event_unit.sv
// tb_button_event_unit: randomized and directed stimulus for button_event_unit
// with a per-cycle scoreboard fed by a behavioural model of the button rules.
module tb_button_event_unit;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;
  localparam logic [N-1:0] MASK = 5'b11000;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] level;
  logic [N-1:0] pulse;
  logic [2*N-1:0] state_dbg;

  always #5 clk = ~clk;

  button_event_unit #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .level(level), .pulse(pulse), .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  logic [2*N-1:0] exp_q[$];
  int pe0[$];
  int pe1[$];
  int pe3[$];
  int pe4[$];
  int rise1[$];
  logic prev_l1 = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, got, exp, edge_cnt);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw samples from one and two edges ago (the synchroniser delay), the
  // debounced level, how long the synced input has disagreed with it, and
  // for each held button the edge at which its press pulse was issued.
  logic [N-1:0] m_raw1 = '0;
  logic [N-1:0] m_raw2 = '0;
  logic [N-1:0] m_level = '0;
  int           m_run[N];
  bit           m_active[N];
  int           m_t0[N];

  task automatic model_step();
    logic [N-1:0] nl;
    logic [N-1:0] np;
    int el;
    edge_cnt++;
    if (reset) begin
      m_raw1 = '0;
      m_raw2 = '0;
      m_level = '0;
      for (int b = 0; b < N; b++) begin
        m_run[b] = 0;
        m_active[b] = 1'b0;
        m_t0[b] = 0;
      end
      exp_q.push_back('0);
    end else begin
      for (int b = 0; b < N; b++) begin
        // events, from the level as it stood before this edge
        np[b] = 1'b0;
        if (!m_level[b]) begin
          m_active[b] = 1'b0;
        end else if (!m_active[b]) begin
          m_active[b] = 1'b1;
          m_t0[b] = edge_cnt;
          np[b] = 1'b1;
        end else if (MASK[b]) begin
          el = edge_cnt - m_t0[b];
          np[b] = (el == RD) || (el > RD && ((el - RD) % RR) == 0);
        end
        // level flips once the synced input disagreed for D consecutive edges
        nl[b] = m_level[b];
        if (m_raw2[b] != m_level[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            nl[b] = m_raw2[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_level = nl;
      m_raw2 = m_raw1;
      m_raw1 = btn_raw;
      exp_q.push_back({nl, np});
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- monitor ----------------
  initial forever begin
    logic [2*N-1:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({level, pulse} !== e) begin
        errors++;
        $display("FAIL out_cycle: edge %0d level/pulse got %b/%b, expected %b/%b",
                 edge_cnt, level, pulse, e[2*N-1:N], e[N-1:0]);
      end
    end
    if (!reset) begin
      if (pulse[0]) pe0.push_back(edge_cnt);
      if (pulse[1]) pe1.push_back(edge_cnt);
      if (pulse[3]) pe3.push_back(edge_cnt);
      if (pulse[4]) pe4.push_back(edge_cnt);
      if (level[1] && !prev_l1) rise1.push_back(edge_cnt);
    end
    prev_l1 = level[1];
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive v for n rising edges.
  task automatic hold(input logic [N-1:0] v, input int n);
    btn_raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    pe0.delete(); pe1.delete(); pe3.delete(); pe4.delete(); rise1.delete();
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock.
  task automatic pulse_reset(input string nm);
    #2 reset = 1'b1;
    #1;
    chk({nm, "_level_async"}, int'(level), 0);
    chk({nm, "_pulse_async"}, int'(pulse), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Offset (from E0) of the k-th pulse of a held button.
  function automatic int nth_pulse(input int k);
    return (k == 0) ? D + 2 : D + 2 + RD + (k - 1) * RR;
  endfunction

  // Compare a pulse train against a press at e0 held for len edges.
  task automatic check_train(input string nm, input int q[$], input int e0,
                             input int len, input bit rep);
    int n_exp;
    n_exp = 1;
    if (rep) begin
      while (nth_pulse(n_exp) <= len + D + 1) n_exp++;
    end
    chk({nm, "_count"}, q.size(), n_exp);
    for (int k = 0; k < n_exp && k < q.size(); k++)
      chk({nm, "_edge"}, q[k] - e0, nth_pulse(k));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0;
    int seg[N];
    logic [N-1:0] v;

    repeat (3) @(negedge clk);
    #2;
    chk("reset_level", int'(level), 0);
    chk("reset_pulse", int'(pulse), 0);
    @(negedge clk);
    reset = 1'b0;
    hold('0, 10);

    // clean press of bit 1, not in the repeat mask
    clear_logs();
    e0 = edge_cnt + 1;
    hold(5'b00010, 30);
    hold('0, 15);
    chk("press1_rise_count", rise1.size(), 1);
    if (rise1.size() > 0) chk("press1_rise_edge", rise1[0] - e0, D + 1);
    check_train("press1", pe1, e0, 30, 1'b0);

    // bounce on bit 0, then stable high
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      hold(5'b00001, 2);
      hold('0, 2);
    end
    e0 = edge_cnt + 1;
    hold(5'b00001, 20);
    hold('0, 15);
    check_train("bounce0", pe0, e0, 20, 1'b0);

    // auto-repeat on bit 4 held 40 cycles
    clear_logs();
    e0 = edge_cnt + 1;
    hold(5'b10000, 40);
    hold('0, 20);
    check_train("repeat4", pe4, e0, 40, 1'b1);

    // left and right on the same edge
    clear_logs();
    e0 = edge_cnt + 1;
    hold(5'b11000, 20);
    hold('0, 20);
    check_train("dual4", pe4, e0, 20, 1'b1);
    check_train("dual3", pe3, e0, 20, 1'b1);

    // reset mid-repeat while bit 4 stays held (lands on a repeat pulse)
    hold(5'b10000, 26);
    pulse_reset("midrep");
    clear_logs();
    e0 = edge_cnt + 1;
    hold(5'b10000, 25);
    hold('0, 15);
    check_train("after_reset4", pe4, e0, 25, 1'b1);

    // randomized segments: short bounces and long holds on every bit
    v = '0;
    for (int b = 0; b < N; b++) seg[b] = $urandom_range(1, 20);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        seg[b]--;
        if (seg[b] <= 0) begin
          v[b] = ~v[b];
          seg[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 45)
                                               : $urandom_range(1, 6);
        end
      end
      hold(v, 1);
      if (c == 1500) pulse_reset("rand");
    end
    hold('0, 20);

    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_event_unit.md
# button_event_unit

Front-end input conditioner for the board's five push-buttons (left, right, up, center, down). It synchronises each raw pad into the clock domain, debounces it, and converts each press into a single-cycle event pulse. Selected buttons also emit auto-repeat pulses while held. It sits directly upstream of the processor top level, which consumes `pulse` as its step, memory-scroll and reset commands and `level` wherever a held state is needed.

## Interface
Parameters:
- `N_BTN`, 5: number of buttons; bit order {left, right, up, center, down} = [4:0]
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive cycles a synchronised input must differ from `level` before `level` follows it (10 ms at 100 MHz); ≥2
- `REPEAT_DELAY`, 50_000_000: cycles from first pulse to first repeat pulse; ≥2
- `REPEAT_RATE`, 10_000_000: cycles between subsequent repeat pulses; ≥2
- `REPEAT_MASK`, 5'b11000: bit set = button auto-repeats (left, right only by default)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `btn_raw`  in  N_BTN  raw, unsynchronised, bouncing pad inputs
- `level`  out  N_BTN  debounced button state, registered
- `pulse`  out  N_BTN  one-cycle press/repeat events, registered

## Operation
- Each bit is an independent, identical channel. No cross-channel priority: simultaneous events on different bits produce simultaneous pulses.
- Synchroniser: two flops, `btn_raw` → `s1` → `s2`. Reset value 0.
- Debounce: counter `dcnt` of width $clog2(DEBOUNCE_CYCLES).
  - If `s2` == `level`: `dcnt` <= 0.
  - Else if `dcnt` == DEBOUNCE_CYCLES-1: `level` <= `s2`, `dcnt` <= 0.
  - Else: `dcnt` <= `dcnt`+1.
  - Any single-cycle agreement with `level` restarts the count.
- Event FSM per channel, states IDLE, HOLD, REPEAT. Timer `rcnt` is wide enough for max(REPEAT_DELAY, REPEAT_RATE).
  - IDLE: if `level`=1, then `pulse` <= 1, `rcnt` <= 0, go to HOLD.
  - HOLD: if `level`=0, go to IDLE.
    - Else if the mask bit is clear, stay in HOLD.
    - Else if `rcnt` == REPEAT_DELAY-1, then `pulse` <= 1, `rcnt` <= 0, go to REPEAT.
    - Else `rcnt`+1.
  - REPEAT: if `level`=0, go to IDLE.
    - Else if `rcnt` == REPEAT_RATE-1, then `pulse` <= 1, `rcnt` <= 0.
    - Else `rcnt`+1.
  - `pulse` is 0 in every cycle not listed above.
  - Release never generates a pulse.
  - Leaving HOLD or REPEAT for IDLE clears `rcnt`.
- Reset: `s1`, `s2`, `level`, `pulse`, `dcnt` and `rcnt` all go to 0, and the FSM goes to IDLE, asynchronously. A button held across reset deassertion is treated as a new press: it debounces again and produces exactly one press pulse.

## Timing
- Edge numbering: E0 is the first clock edge that samples `btn_raw`=1, given a clean input.
- Press latency:
  - `s2` = 1 after E1.
  - `level` = 1 after E(D+1), where D = DEBOUNCE_CYCLES.
  - `pulse` is high for the single cycle following E(D+2).
- Release latency: `level` = 0 after E(D+1), counted from the first edge that samples 0. No pulse is generated.
- Repeat spacing:
  - The first repeat pulse occurs exactly REPEAT_DELAY cycles after the press pulse.
  - Later repeat pulses follow every REPEAT_RATE cycles.
- Bounce rejection: glitches shorter than D cycles never change `level`.
- `pulse` is never high for two consecutive cycles on one bit.

## Test plan
All scenarios use D=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Clean press of `btn_raw[1]`, held 30 cycles:
  - `level[1]` rises after E5.
  - `pulse[1]` is high for one cycle after E6.
  - No further pulses, since bit 1 is not in the mask.
- Bounce on bit 0: toggle every 2 cycles for 12 cycles, then hold 1.
  - No pulse while bouncing.
  - Exactly one pulse, D+3 edges after the final stable rise.
- Auto-repeat on `btn_raw[4]` held 40 cycles:
  - Press pulse after E6.
  - Second pulse 10 cycles later.
  - Then pulses every 3 cycles until release.
  - No pulse after `level[4]` falls.
- Left and right pressed on the same edge and held 20 cycles:
  - `pulse[4]` and `pulse[3]` assert in the same cycle.
  - Each repeats identically.
- Reset mid-repeat while bit 4 is still held:
  - `level` and `pulse` read 0 immediately, without waiting for a clock.
  - After reset deasserts, exactly one press pulse appears D+3 edges later.
  - Repeat pulses then follow 10 cycles after that.
